// File: rtl/synth_cmd_decoder.sv
// Host command byte decoder for the synthesizer: parses opcode/argument bytes from
// the UART receiver and drives modulator, attenuation and voice-allocation registers.
module synth_cmd_decoder #(
   parameter int N_VOICES       = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic [23:0]              mod_fcw,
   output logic [4:0]               mod_shift,
   output logic [4:0]               synth_shift,
   output logic [24*N_VOICES-1:0]   carrier_fcws,
   output logic [N_VOICES-1:0]      note_en,
   output logic                     cmd_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARGS, EXEC} state_t;

   state_t              r_state;
   logic [2:0]          r_opcode;
   logic [1:0]          r_cnt;
   logic [7:0]          r_arg0;
   logic [7:0]          r_arg1;
   logic [7:0]          r_arg2;
   logic [TW-1:0]       r_timer;
   logic [23:0]         r_mod_fcw;
   logic [4:0]          r_mod_shift;
   logic [4:0]          r_synth_shift;
   logic [23:0]         r_carrier [N_VOICES];
   logic [N_VOICES-1:0] r_note_en;
   logic                r_cmd_err;

   logic                w_accept;
   logic [23:0]         w_fcw;
   logic [1:0]          w_last_cnt;
   logic [N_VOICES-1:0] w_match;
   logic [N_VOICES-1:0] w_free_oh;
   logic [N_VOICES-1:0] w_match_oh;
   logic                w_free_any;
   logic                w_match_any;

   assign rx_ready   = (r_state != EXEC);
   assign w_accept   = rx_valid && rx_ready;
   assign w_fcw      = {r_arg2, r_arg1, r_arg0};
   assign w_last_cnt = (r_opcode == 3'd2 || r_opcode == 3'd5) ? 2'd0 : 2'd2;

   assign mod_fcw     = r_mod_fcw;
   assign mod_shift   = r_mod_shift;
   assign synth_shift = r_synth_shift;
   assign note_en     = r_note_en;
   assign cmd_err     = r_cmd_err;

   genvar gi;
   generate
      for (gi = 0; gi < N_VOICES; gi++) begin : g_voice
         assign carrier_fcws[24*gi +: 24] = r_carrier[gi];
         assign w_match[gi] = r_note_en[gi] && (r_carrier[gi] == w_fcw);
      end
   endgenerate

   // Lowest-index priority picks for allocation (free voice) and release (matching voice).
   always_comb begin
      w_free_oh   = '0;
      w_match_oh  = '0;
      w_free_any  = 1'b0;
      w_match_any = 1'b0;
      for (int i = 0; i < N_VOICES; i++) begin
         if (!r_note_en[i] && !w_free_any) begin
            w_free_oh[i] = 1'b1;
            w_free_any   = 1'b1;
         end
         if (w_match[i] && !w_match_any) begin
            w_match_oh[i] = 1'b1;
            w_match_any   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_opcode      <= 3'd0;
         r_cnt         <= 2'd0;
         r_arg0        <= 8'd0;
         r_arg1        <= 8'd0;
         r_arg2        <= 8'd0;
         r_timer       <= '0;
         r_mod_fcw     <= 24'd0;
         r_mod_shift   <= 5'd0;
         r_synth_shift <= 5'd0;
         r_note_en     <= '0;
         r_cmd_err     <= 1'b0;
         for (int i = 0; i < N_VOICES; i++) r_carrier[i] <= 24'd0;
      end else begin
         r_cmd_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (rx_data >= 8'd1 && rx_data <= 8'd5) begin
                     r_opcode <= rx_data[2:0];
                     r_cnt    <= 2'd0;
                     r_timer  <= '0;
                     r_state  <= ARGS;
                  end else if (rx_data == 8'd6) begin
                     r_opcode <= 3'd6;
                     r_state  <= EXEC;
                  end else begin
                     r_cmd_err <= 1'b1;
                  end
               end
            end
            ARGS: begin
               if (w_accept) begin
                  case (r_cnt)
                     2'd0:    r_arg0 <= rx_data;
                     2'd1:    r_arg1 <= rx_data;
                     default: r_arg2 <= rx_data;
                  endcase
                  r_cnt   <= r_cnt + 2'd1;
                  r_timer <= '0;
                  if (r_cnt == w_last_cnt) r_state <= EXEC;
               end else if (r_timer == TIMEOUT_LAST) begin
                  r_state   <= IDLE;
                  r_timer   <= '0;
                  r_cmd_err <= 1'b1;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            EXEC: begin
               r_state <= IDLE;
               case (r_opcode)
                  3'd1: r_mod_fcw   <= w_fcw;
                  3'd2: r_mod_shift <= r_arg0[4:0];
                  3'd3: begin
                     if (w_free_any) begin
                        for (int i = 0; i < N_VOICES; i++) begin
                           if (w_free_oh[i]) begin
                              r_carrier[i] <= w_fcw;
                              r_note_en[i] <= 1'b1;
                           end
                        end
                     end else begin
                        r_cmd_err <= 1'b1;
                     end
                  end
                  // A stop with no matching active voice is silently ignored.
                  3'd4: begin
                     for (int i = 0; i < N_VOICES; i++) begin
                        if (w_match_oh[i]) r_note_en[i] <= 1'b0;
                     end
                  end
                  3'd5: r_synth_shift <= r_arg0[4:0];
                  3'd6: r_note_en     <= '0;
                  default: ;
               endcase
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_synth_cmd_decoder.sv
// Self-checking bench for synth_cmd_decoder: directed scenarios plus randomized
// command streams compared against a behavioural model of the command set.
module tb_synth_cmd_decoder;

   localparam int NV = 4;
   localparam int TO = 50;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [23:0]       mod_fcw;
   logic [4:0]        mod_shift;
   logic [4:0]        synth_shift;
   logic [24*NV-1:0]  carrier_fcws;
   logic [NV-1:0]     note_en;
   logic              cmd_err;

   synth_cmd_decoder #(.N_VOICES(NV), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .mod_fcw(mod_fcw), .mod_shift(mod_shift), .synth_shift(synth_shift),
      .carrier_fcws(carrier_fcws), .note_en(note_en), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int err_seen = 0;
   int exp_err  = 0;
   bit cnt_ready = 1'b0;
   int ready_low = 0;

   always @(negedge clk) begin
      if (cmd_err === 1'b1) err_seen++;
      if (cnt_ready && rx_ready !== 1'b1) ready_low++;
   end

   // Behavioural model of the decoder's architectural state
   logic [23:0] m_mod_fcw;
   logic [4:0]  m_mod_shift;
   logic [4:0]  m_synth_shift;
   logic [23:0] m_fcw [NV];
   bit          m_en  [NV];

   function automatic void model_reset();
      m_mod_fcw = 0; m_mod_shift = 0; m_synth_shift = 0;
      for (int i = 0; i < NV; i++) begin m_fcw[i] = 0; m_en[i] = 0; end
   endfunction

   function automatic int nargs(input logic [7:0] op);
      if (op == 1 || op == 3 || op == 4) return 3;
      if (op == 2 || op == 5) return 1;
      return 0;
   endfunction

   function automatic void model_exec(input logic [7:0] op, input logic [23:0] arg);
      int slot;
      slot = -1;
      case (op)
         8'd1: m_mod_fcw = arg;
         8'd2: m_mod_shift = arg[4:0];
         8'd3: begin
            for (int i = NV - 1; i >= 0; i--) if (!m_en[i]) slot = i;
            if (slot < 0) exp_err++;
            else begin m_fcw[slot] = arg; m_en[slot] = 1; end
         end
         8'd4: begin
            for (int i = NV - 1; i >= 0; i--) if (m_en[i] && m_fcw[i] == arg) slot = i;
            if (slot >= 0) m_en[slot] = 0;
         end
         8'd5: m_synth_shift = arg[4:0];
         8'd6: for (int i = 0; i < NV; i++) m_en[i] = 0;
         default: exp_err++;
      endcase
   endfunction

   function automatic logic [24*NV-1:0] exp_fcws();
      logic [24*NV-1:0] r;
      for (int i = 0; i < NV; i++) r[24*i +: 24] = m_fcw[i];
      return r;
   endfunction

   function automatic logic [NV-1:0] exp_en();
      logic [NV-1:0] r;
      for (int i = 0; i < NV; i++) r[i] = m_en[i];
      return r;
   endfunction

   // Presents one byte and returns just after the edge that accepts it (rx_valid left high).
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (rx_ready !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (n >= 8) begin
         n_checks++; n_errors++;
         $display("FAIL accept_wait: rx_ready=%b for %0d cycles, required 1", rx_ready, n);
      end
      @(posedge clk); #1;
   endtask

   task automatic do_cmd(input logic [7:0] op, input logic [23:0] arg, input int gap);
      int na;
      na = nargs(op);
      $display("cmd op=%0d arg=%06h gap=%0d", op, arg, gap);
      send_byte(op);
      for (int k = 0; k < na; k++) begin
         if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
         send_byte(arg[8*k +: 8]);
      end
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_exec(op, arg);
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      $display("reset applied");
      n_checks++;
      if ({mod_fcw, mod_shift, synth_shift} !== 34'd0) begin
         n_errors++; $display("FAIL reset_regs: got %h required 0", {mod_fcw, mod_shift, synth_shift});
      end
      n_checks++;
      if (carrier_fcws !== '0 || note_en !== '0) begin
         n_errors++; $display("FAIL reset_voices: got fcws=%h en=%b required 0", carrier_fcws, note_en);
      end
      n_checks++;
      if (cmd_err !== 1'b0 || rx_ready !== 1'b1) begin
         n_errors++; $display("FAIL reset_hs: got err=%b ready=%b required 0/1", cmd_err, rx_ready);
      end
   endtask

   task automatic test_mod_shift();
      $display("cmd op=2 arg=08 latency check");
      send_byte(8'd2);
      send_byte(8'd8);
      rx_valid = 1'b0;
      n_checks++;
      if (rx_ready !== 1'b0 || mod_shift !== 5'd0) begin
         n_errors++; $display("FAIL exec_cycle: got ready=%b mod_shift=%0d required 0/0", rx_ready, mod_shift);
      end
      @(posedge clk); #1;
      model_exec(8'd2, 24'd8);
      n_checks++;
      if (mod_shift !== 5'd8 || rx_ready !== 1'b1) begin
         n_errors++; $display("FAIL mod_shift_apply: got %0d ready=%b required 8/1", mod_shift, rx_ready);
      end
      n_checks++;
      if (mod_fcw !== 24'd0 || synth_shift !== 5'd0 || note_en !== '0 || carrier_fcws !== '0) begin
         n_errors++; $display("FAIL mod_shift_others: got fcw=%h ss=%0d en=%b required all 0", mod_fcw, synth_shift, note_en);
      end
   endtask

   task automatic test_fcw_shift();
      do_cmd(8'd1, 24'h111111, 0);
      n_checks++;
      if (mod_fcw !== 24'd1118481) begin
         n_errors++; $display("FAIL mod_fcw: got %0d required 1118481", mod_fcw);
      end
      do_cmd(8'd5, 24'd2, 0);
      n_checks++;
      if (synth_shift !== 5'd2 || mod_shift !== m_mod_shift) begin
         n_errors++; $display("FAIL synth_shift: got ss=%0d ms=%0d required 2/%0d", synth_shift, mod_shift, m_mod_shift);
      end
   endtask

   task automatic test_notes();
      int e0;
      do_cmd(8'd3, 24'h2AAAAA, 0);
      n_checks++;
      if (carrier_fcws[23:0] !== 24'd2796202 || note_en !== 4'b0001) begin
         n_errors++; $display("FAIL note_start0: got fcw=%0d en=%b required 2796202/0001", carrier_fcws[23:0], note_en);
      end
      do_cmd(8'd3, 24'd1006202, 1);
      n_checks++;
      if (carrier_fcws[47:24] !== 24'd1006202 || note_en !== 4'b0011) begin
         n_errors++; $display("FAIL note_start1: got fcw=%0d en=%b required 1006202/0011", carrier_fcws[47:24], note_en);
      end
      do_cmd(8'd3, 24'h000100, 0);
      do_cmd(8'd3, 24'h2AAAAA, 0);
      e0 = err_seen;
      do_cmd(8'd3, 24'd5, 0);
      n_checks++;
      if (err_seen - e0 !== 1 || note_en !== 4'b1111 || carrier_fcws !== exp_fcws()) begin
         n_errors++; $display("FAIL voices_full: got errs=%0d en=%b fcws=%h required 1/1111/%h", err_seen - e0, note_en, carrier_fcws, exp_fcws());
      end
      do_cmd(8'd4, 24'd2796202, 0);
      n_checks++;
      if (note_en !== 4'b1110) begin
         n_errors++; $display("FAIL note_stop_lowest: got en=%b required 1110", note_en);
      end
      e0 = err_seen;
      do_cmd(8'd4, 24'd7, 0);
      n_checks++;
      if (note_en !== 4'b1110 || err_seen != e0) begin
         n_errors++; $display("FAIL note_stop_nomatch: got en=%b errs=%0d required 1110/0", note_en, err_seen - e0);
      end
      do_cmd(8'd3, 24'h00ABCD, 0);
      n_checks++;
      if (note_en !== 4'b1111 || carrier_fcws[23:0] !== 24'h00ABCD || carrier_fcws[95:72] !== 24'h2AAAAA) begin
         n_errors++; $display("FAIL note_reuse: got en=%b v0=%h v3=%h required 1111/00abcd/2aaaaa", note_en, carrier_fcws[23:0], carrier_fcws[95:72]);
      end
   endtask

   task automatic test_bad_opcode();
      int e0;
      e0 = err_seen;
      do_cmd(8'h09, 24'd0, 0);
      n_checks++;
      if (err_seen - e0 !== 1 || rx_ready !== 1'b1) begin
         n_errors++; $display("FAIL bad_opcode: got errs=%0d ready=%b required 1/1", err_seen - e0, rx_ready);
      end
      do_cmd(8'd2, 24'd5, 0);
      n_checks++;
      if (mod_shift !== 5'd5) begin
         n_errors++; $display("FAIL after_bad_opcode: got mod_shift=%0d required 5", mod_shift);
      end
   endtask

   task automatic test_timeout();
      int e0;
      e0 = err_seen;
      $display("cmd op=1 partial arg=34 then idle");
      send_byte(8'd1);
      send_byte(8'h34);
      rx_valid = 1'b0;
      repeat (45) @(posedge clk);
      #1;
      n_checks++;
      if (err_seen != e0) begin
         n_errors++; $display("FAIL timeout_early: got errs=%0d after 45 idle cycles required 0", err_seen - e0);
      end
      repeat (15) @(posedge clk);
      #1;
      n_checks++;
      if (err_seen - e0 !== 1 || mod_fcw !== m_mod_fcw) begin
         n_errors++; $display("FAIL timeout_abort: got errs=%0d fcw=%h required 1/%h", err_seen - e0, mod_fcw, m_mod_fcw);
      end
      do_cmd(8'd2, 24'd3, 0);
      n_checks++;
      if (mod_shift !== 5'd3 || mod_fcw !== m_mod_fcw) begin
         n_errors++; $display("FAIL after_timeout: got ms=%0d fcw=%h required 3/%h", mod_shift, mod_fcw, m_mod_fcw);
      end
   endtask

   task automatic test_reset_mid();
      $display("cmd op=3 partial arg=01 then reset");
      send_byte(8'd3);
      send_byte(8'h01);
      rx_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      n_checks++;
      if (note_en !== '0 || carrier_fcws !== '0 || {mod_fcw, mod_shift, synth_shift} !== 34'd0) begin
         n_errors++; $display("FAIL reset_mid: got en=%b fcws=%h required 0", note_en, carrier_fcws);
      end
      do_cmd(8'd6, 24'd0, 0);
      do_cmd(8'd2, 24'd5, 0);
      n_checks++;
      if (note_en !== '0 || carrier_fcws !== '0 || mod_shift !== 5'd5) begin
         n_errors++; $display("FAIL reset_discard: got en=%b fcws=%h ms=%0d required 0/0/5", note_en, carrier_fcws, mod_shift);
      end
   endtask

   task automatic test_all_off();
      do_cmd(8'd3, 24'h123456, 0);
      do_cmd(8'd3, 24'h00FFEE, 0);
      do_cmd(8'd3, 24'h800001, 0);
      n_checks++;
      if (note_en !== 4'b0111) begin
         n_errors++; $display("FAIL all_off_setup: got en=%b required 0111", note_en);
      end
      do_cmd(8'd6, 24'd0, 0);
      n_checks++;
      if (note_en !== 4'b0000 || carrier_fcws[71:0] !== {24'h800001, 24'h00FFEE, 24'h123456}) begin
         n_errors++; $display("FAIL all_off: got en=%b fcws=%h required 0000/retained", note_en, carrier_fcws);
      end
   endtask

   task automatic test_back_to_back();
      int e0;
      e0 = err_seen;
      ready_low = 0;
      cnt_ready = 1'b1;
      $display("stream 2,4,5,1 with rx_valid held");
      send_byte(8'd2);
      send_byte(8'd4);
      send_byte(8'd5);
      send_byte(8'd1);
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cnt_ready = 1'b0;
      model_exec(8'd2, 24'd4);
      model_exec(8'd5, 24'd1);
      n_checks++;
      if (ready_low !== 2) begin
         n_errors++; $display("FAIL b2b_bubbles: got %0d not-ready cycles required 2", ready_low);
      end
      n_checks++;
      if (mod_shift !== 5'd4 || synth_shift !== 5'd1 || err_seen != e0) begin
         n_errors++; $display("FAIL b2b_result: got ms=%0d ss=%0d errs=%0d required 4/1/0", mod_shift, synth_shift, err_seen - e0);
      end
   endtask

   task automatic test_random();
      logic [23:0] pool [5];
      logic [7:0]  op;
      logic [23:0] arg;
      int r, e0, x0;
      for (int i = 0; i < 5; i++) pool[i] = 24'($urandom);
      for (int it = 0; it < 150; it++) begin
         r = $urandom_range(0, 99);
         if (r < 30)      op = 8'd3;
         else if (r < 55) op = 8'd4;
         else if (r < 60) op = 8'd6;
         else if (r < 70) op = 8'd1;
         else if (r < 80) op = 8'd2;
         else if (r < 90) op = 8'd5;
         else if (r < 94) op = 8'd0;
         else             op = 8'($urandom_range(7, 255));
         if (op == 8'd3 || op == 8'd4) arg = pool[$urandom_range(0, 4)];
         else                          arg = 24'($urandom);
         e0 = err_seen;
         x0 = exp_err;
         do_cmd(op, arg, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
         n_checks++;
         if ({mod_fcw, mod_shift, synth_shift} !== {m_mod_fcw, m_mod_shift, m_synth_shift}) begin
            n_errors++; $display("FAIL rand_regs[%0d]: got %h required %h", it, {mod_fcw, mod_shift, synth_shift}, {m_mod_fcw, m_mod_shift, m_synth_shift});
         end
         n_checks++;
         if (carrier_fcws !== exp_fcws() || note_en !== exp_en()) begin
            n_errors++; $display("FAIL rand_voices[%0d]: got %h/%b required %h/%b", it, carrier_fcws, note_en, exp_fcws(), exp_en());
         end
         n_checks++;
         if (err_seen - e0 !== exp_err - x0) begin
            n_errors++; $display("FAIL rand_err[%0d]: got %0d pulses required %0d", it, err_seen - e0, exp_err - x0);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'd0;
      model_reset();
      test_reset();
      test_mod_shift();
      test_fcw_shift();
      test_notes();
      test_bad_opcode();
      test_timeout();
      test_reset_mid();
      test_all_off();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
